// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID/timestamp from the ID slave, retries on mismatch,
// then hands the slave to the CPU via a one-wait-state Avalon-MM port. Optional IRQ: SYSID_CHK_IRQ_EN.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1581413829,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic        sid_address,
    input  logic [31:0] sid_readdata,
    output logic        check_done,
    output logic        check_pass
`ifdef SYSID_CHK_IRQ_EN
    ,
    output logic        check_irq
`endif
);

    typedef enum logic [1:0] {RD_ID, RD_TS, CMP, DONE} state_t;

    localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);

    state_t      state;
    state_t      state_next;
    logic [3:0]  retry_cnt;
    logic        rsp_pend;
    logic [31:0] id_q;
    logic [31:0] ts_q;
    logic        match;
    logic        cmd_write;
    logic        recheck;
    logic        read_accept;
    logic        fail_exit;
    logic        irq_bit;
    logic [31:0] status_word;
    logic [31:0] read_mux;

    assign match       = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
    assign cmd_write   = (state == DONE) && cpu_write && (cpu_address == 2'd3);
    assign recheck     = cmd_write && cpu_writedata[0];
    assign read_accept = (state == DONE) && cpu_read && !rsp_pend;
    assign fail_exit   = (state == CMP) && !match && (retry_cnt == MAX_RETRY_W);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RD_ID;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RD_ID:   state_next = RD_TS;
            RD_TS:   state_next = CMP;
            CMP:     state_next = (match || retry_cnt == MAX_RETRY_W) ? DONE : RD_ID;
            DONE:    state_next = recheck ? RD_ID : DONE;
            default: state_next = RD_ID;
        endcase
    end

    // Outputs: the pending read response completes even if a re-check has already left DONE
    always_comb begin
        sid_address     = 1'b0;
        cpu_waitrequest = 1'b0;
        case (state)
            RD_TS:   sid_address = 1'b1;
            DONE:    sid_address = cpu_address[0];
            default: sid_address = 1'b0;
        endcase
        if (cpu_read) begin
            cpu_waitrequest = !rsp_pend;
        end else if (cpu_write) begin
            cpu_waitrequest = (state != DONE);
        end
    end

    always_ff @(posedge clock) begin
        if (state == RD_ID) id_q <= sid_readdata;
        if (state == RD_TS) ts_q <= sid_readdata;
    end

`ifdef SYSID_CHK_IRQ_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            check_irq <= 1'b0;
        end else if (fail_exit) begin
            check_irq <= 1'b1;
        end else if (cmd_write && cpu_writedata[1]) begin
            check_irq <= 1'b0;
        end
    end
    assign irq_bit = check_irq;
`else
    assign irq_bit = 1'b0;
`endif

    assign status_word = {25'd0, irq_bit, retry_cnt, check_pass, check_done};

    always_comb begin
        case (cpu_address)
            2'd0, 2'd1: read_mux = sid_readdata;
            2'd2:       read_mux = status_word;
            default:    read_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt    <= 4'd0;
            check_done   <= 1'b0;
            check_pass   <= 1'b0;
            cpu_readdata <= 32'd0;
            rsp_pend     <= 1'b0;
        end else begin
            if (state == CMP && !match && retry_cnt != MAX_RETRY_W) begin
                retry_cnt <= retry_cnt + 4'd1;
            end else if (recheck) begin
                retry_cnt <= 4'd0;
            end

            if (state == CMP && state_next == DONE) begin
                check_done <= 1'b1;
                check_pass <= match;
            end else if (recheck) begin
                check_done <= 1'b0;
                check_pass <= 1'b0;
            end

            if (rsp_pend) begin
                rsp_pend <= 1'b0;
            end else if (read_accept) begin
                rsp_pend     <= 1'b1;
                cpu_readdata <= read_mux;
            end
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: read expectations are queued by the stimulus
// and checked by a monitor whenever a read completes; control outputs are checked inline.
module tb_sysid_boot_checker;

    localparam logic [31:0] TS_OK  = 32'd1581413829;
    localparam logic [31:0] BAD_ID = 32'h0000_DEAD;
`ifdef SYSID_CHK_IRQ_EN
    localparam logic [31:0] STAT_FAIL = 32'h4D;
`else
    localparam logic [31:0] STAT_FAIL = 32'h0D;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic        sid_address;
    logic [31:0] sid_readdata;
    logic        check_done;
    logic        check_pass;
`ifdef SYSID_CHK_IRQ_EN
    logic        check_irq;
`endif

    logic [31:0] id_val;
    logic [31:0] ts_val;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;

    assign sid_readdata = sid_address ? ts_val : id_val;

    sysid_boot_checker dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_address    (cpu_address),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_writedata  (cpu_writedata),
        .cpu_readdata   (cpu_readdata),
        .cpu_waitrequest(cpu_waitrequest),
        .sid_address    (sid_address),
        .sid_readdata   (sid_readdata),
        .check_done     (check_done),
        .check_pass     (check_pass)
`ifdef SYSID_CHK_IRQ_EN
        ,
        .check_irq      (check_irq)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed read is scored against the oldest queued expectation
    always @(negedge clock) begin
        if (reset_n && cpu_read && !cpu_waitrequest) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got 0x%08h required no response", cpu_readdata);
            end else begin
                exp_word = exp_q.pop_front();
                chk("readdata", cpu_readdata, exp_word);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic cpu_rd(input logic [1:0] addr, input logic [31:0] exp, input int exp_waits);
        int waits;
        exp_q.push_back(exp);
        cpu_address = addr;
        cpu_read    = 1'b1;
        waits       = 0;
        @(negedge clock);
        while (cpu_waitrequest && waits < 64) begin
            waits++;
            @(negedge clock);
        end
        if (cpu_waitrequest) void'(exp_q.pop_back());
        chk("read_wait_states", waits, exp_waits);
        @(posedge clock);
        #1 cpu_read = 1'b0;
    endtask

    task automatic cpu_wr(input logic [1:0] addr, input logic [31:0] data);
        cpu_address   = addr;
        cpu_writedata = data;
        cpu_write     = 1'b1;
        @(negedge clock);
        chk("write_waitrequest", cpu_waitrequest, 1'b0);
        @(posedge clock);
        #1 cpu_write = 1'b0;
    endtask

    task automatic chk_flags(input string name, input logic done, input logic pass);
        chk({name, "_done"}, check_done, done);
        chk({name, "_pass"}, check_pass, pass);
    endtask

    initial begin
        reset_n       = 1'b0;
        cpu_address   = 2'd0;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_writedata = 32'd0;
        id_val        = 32'd0;
        ts_val        = TS_OK;

        // Reset state and first-pass success
        tick(2);
        chk_flags("reset", 1'b0, 1'b0);
        chk("reset_readdata", cpu_readdata, 32'd0);
        chk("reset_sid_address", sid_address, 1'b0);
        reset_n = 1'b1;
        tick(2);
        chk_flags("edge2", 1'b0, 1'b0);
        tick(1);
        chk_flags("edge3", 1'b1, 1'b1);
        cpu_rd(2'd2, 32'h3, 1);
        cpu_rd(2'd0, 32'd0, 1);
        cpu_rd(2'd1, TS_OK, 1);
        cpu_rd(2'd3, 32'd0, 1);
        cpu_address = 2'd1;
        #1 chk("done_sid_address", sid_address, 1'b1);
        tick(1);
        cpu_wr(2'd2, 32'hFFFF_FFFF);
        cpu_wr(2'd0, 32'hFFFF_FFFF);
        cpu_rd(2'd2, 32'h3, 1);

        // Re-check command
        cpu_wr(2'd3, 32'h1);
        chk_flags("recheck_fall", 1'b0, 1'b0);
        tick(2);
        chk_flags("recheck_e2", 1'b0, 1'b0);
        tick(1);
        chk_flags("recheck_e3", 1'b1, 1'b1);
        cpu_rd(2'd2, 32'h3, 1);

        // Persistent mismatch: all retries exhausted
        id_val  = BAD_ID;
        reset_n = 1'b0;
        #1 chk("async_reset_readdata", cpu_readdata, 32'd0);
        tick(1);
        reset_n = 1'b1;
        cpu_address = 2'd3;
        cpu_writedata = 32'h1;
        cpu_write = 1'b1;
        @(negedge clock);
        chk("busy_write_wait", cpu_waitrequest, 1'b1);
        @(posedge clock);
        #1 cpu_write = 1'b0;
        tick(10);
        chk_flags("fail_e11", 1'b0, 1'b0);
        tick(1);
        chk_flags("fail_e12", 1'b1, 1'b0);
`ifdef SYSID_CHK_IRQ_EN
        chk("fail_irq", check_irq, 1'b1);
`endif
        cpu_rd(2'd2, STAT_FAIL, 1);

        // Reset during RD_TS of a retry pass
        cpu_wr(2'd3, 32'h1);
        tick(4);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_readdata", cpu_readdata, 32'd0);
        chk_flags("midreset", 1'b0, 1'b0);
`ifdef SYSID_CHK_IRQ_EN
        chk("midreset_irq", check_irq, 1'b0);
`endif
        id_val = 32'd0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick(2);
        chk_flags("fresh_e2", 1'b0, 1'b0);
        tick(1);
        chk_flags("fresh_e3", 1'b1, 1'b1);
        cpu_rd(2'd2, 32'h3, 1);

        // Failure via re-check, then command bit1 (IRQ clear; ignored otherwise)
        id_val = BAD_ID;
        cpu_wr(2'd3, 32'h1);
        tick(11);
        chk_flags("refail_e11", 1'b0, 1'b0);
        tick(1);
        chk_flags("refail_e12", 1'b1, 1'b0);
`ifdef SYSID_CHK_IRQ_EN
        chk("refail_irq", check_irq, 1'b1);
`endif
        cpu_wr(2'd3, 32'h2);
        chk_flags("bit1_only", 1'b1, 1'b0);
`ifdef SYSID_CHK_IRQ_EN
        chk("irq_cleared", check_irq, 1'b0);
`endif
        cpu_rd(2'd2, 32'h0D, 1);

        // Wrong ID on the first pass only
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        id_val = 32'd0;
        tick(4);
        chk_flags("retry1_e5", 1'b0, 1'b0);
        tick(1);
        chk_flags("retry1_e6", 1'b1, 1'b1);
        cpu_rd(2'd2, 32'h07, 1);

        // Read held across the whole check
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        cpu_rd(2'd1, TS_OK, 4);
        chk_flags("held_read", 1'b1, 1'b1);

        tick(2);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
